// File: rtl/ce_gen_multi_if.sv
// Bus bundle for the multi-channel clock-enable generator: per-channel
// configuration in, enable and mid-period strobes out.
interface ce_gen_multi_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ACC_W  = 16
);
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH*CNT_W-1:0] div;
  logic [NUM_CH*ACC_W-1:0] inc;
  logic [NUM_CH-1:0]       ce;
  logic [NUM_CH-1:0]       ce_mid;

  modport master (
    output en, mode, div, inc,
    input  ce, ce_mid
  );

  modport slave (
    input  en, mode, div, inc,
    output ce, ce_mid
  );
endinterface

// File: rtl/ce_gen_multi.sv
// Multi-channel clock-enable generator: per channel, either divide-by-(div+1)
// or a phase-accumulator fractional rate, with period-boundary reconfiguration.
module ce_gen_multi #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           sync,
  ce_gen_multi_if.slave  bus
);

  logic [CNT_W-1:0]  div_w   [NUM_CH];
  logic [ACC_W-1:0]  inc_w   [NUM_CH];
  logic [CNT_W-1:0]  mid_w   [NUM_CH];
  logic [ACC_W:0]    sum_w   [NUM_CH];

  logic [CNT_W-1:0]  cnt_q     [NUM_CH];
  logic [CNT_W-1:0]  cnt_d     [NUM_CH];
  logic [ACC_W-1:0]  acc_q     [NUM_CH];
  logic [ACC_W-1:0]  acc_d     [NUM_CH];
  logic [CNT_W-1:0]  cur_div_q [NUM_CH];
  logic [CNT_W-1:0]  cur_div_d [NUM_CH];
  logic [NUM_CH-1:0] cur_mode_q, cur_mode_d;
  logic [NUM_CH-1:0] ce_q, ce_d;
  logic [NUM_CH-1:0] ce_mid_q, ce_mid_d;

  // Unpack per-channel configuration and precompute mid-point and accumulator sum.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign div_w[g] = bus.div[g*CNT_W +: CNT_W];
    assign inc_w[g] = bus.inc[g*ACC_W +: ACC_W];
    assign mid_w[g] = CNT_W'(({1'b0, cur_div_q[g]} + (CNT_W+1)'(1)) >> 1);
    assign sum_w[g] = {1'b0, acc_q[g]} + {1'b0, inc_w[g]};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i]     <= '0;
        acc_q[i]     <= '0;
        cur_div_q[i] <= div_w[i];
      end
      cur_mode_q <= bus.mode;
      ce_q       <= '0;
      ce_mid_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      cur_div_q  <= cur_div_d;
      cur_mode_q <= cur_mode_d;
      ce_q       <= ce_d;
      ce_mid_q   <= ce_mid_d;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    cur_div_d  = cur_div_q;
    cur_mode_d = cur_mode_q;
    ce_d       = '0;
    ce_mid_d   = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (sync || !bus.en[i]) begin
        // Idle/aligned: hold at period start and keep tracking the inputs.
        cnt_d[i]      = '0;
        acc_d[i]      = '0;
        cur_div_d[i]  = div_w[i];
        cur_mode_d[i] = bus.mode[i];
      end else if (!cur_mode_q[i]) begin
        // Accumulator is parked at 0 so a switch into fractional starts clean.
        acc_d[i]    = '0;
        ce_mid_d[i] = (cur_div_q[i] != '0) && (cnt_q[i] == mid_w[i]);
        if (cnt_q[i] == cur_div_q[i]) begin
          cnt_d[i]      = '0;
          ce_d[i]       = 1'b1;
          cur_div_d[i]  = div_w[i];
          cur_mode_d[i] = bus.mode[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        // Fractional: every edge is a boundary; the carry is the enable.
        cnt_d[i]      = '0;
        acc_d[i]      = sum_w[i][ACC_W-1:0];
        ce_d[i]       = sum_w[i][ACC_W];
        cur_div_d[i]  = div_w[i];
        cur_mode_d[i] = bus.mode[i];
      end
    end
  end

  assign bus.ce     = ce_q;
  assign bus.ce_mid = ce_mid_q;

endmodule

// File: tb/tb_ce_gen_multi.sv
// Directed bench for ce_gen_multi: integer timing, boundary-deferred divisor
// changes, fractional rates, sync alignment and mid-operation reset.
module tb_ce_gen_multi;

  logic clk_sys = 1'b0;
  logic reset;
  logic sync;
  int   checks   = 0;
  int   failures = 0;
  int   pulses;

  always #5 clk_sys = ~clk_sys;

  ce_gen_multi_if #(.NUM_CH(2), .CNT_W(8), .ACC_W(16)) bus ();

  ce_gen_multi #(.NUM_CH(2), .CNT_W(8), .ACC_W(16)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .sync    (sync),
    .bus     (bus)
  );

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // obs/exp are {ce, ce_mid} for one channel.
  task automatic chk(input string tag, input int ch, input logic [1:0] exp);
    logic [1:0] obs;
    obs = {bus.ce[ch], bus.ce_mid[ch]};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ch%0d observed={ce,mid}=%b expected=%b", tag, ch, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    sync  = 1'b0;
    bus.en   = 2'b00;
    bus.mode = 2'b00;
    bus.div  = {8'd3, 8'd5};
    bus.inc  = 32'h0;
    step();
    step();
    chk("reset", 0, 2'b00);
    chk("reset", 1, 2'b00);

    // Test 1: div0=5, en first sampled at edge 0.
    reset = 1'b0;
    bus.en[0] = 1'b1;
    for (int e = 0; e < 18; e++) begin
      step();
      chk($sformatf("int_div5 e%0d", e), 0, {(e % 6) == 5, (e % 6) == 3});
    end

    // Test 2: div0 -> 1 while cnt==2; current period completes at edge 23.
    for (int e = 18; e < 30; e++) begin
      step();
      if (e == 19) bus.div[7:0] = 8'd1;
      chk($sformatf("div_change e%0d", e), 0,
          {(e == 23) || (e == 25) || (e == 27) || (e == 29),
           (e == 21) || (e == 25) || (e == 27) || (e == 29)});
    end

    // Test 4: div0 -> 0 takes effect after the boundary at edge 31.
    bus.div[7:0] = 8'd0;
    for (int e = 30; e < 36; e++) begin
      step();
      chk($sformatf("div0 e%0d", e), 0, {e >= 31, e == 31});
    end
    bus.en[0] = 1'b0;
    step();
    chk("en_off", 0, 2'b00);

    // Test 3: ch1 fractional, inc=0x4000 -> every 4th edge.
    bus.mode[1]     = 1'b1;
    bus.inc[31:16]  = 16'h4000;
    step();
    bus.en[1] = 1'b1;
    for (int f = 0; f < 12; f++) begin
      step();
      chk($sformatf("frac4 f%0d", f), 1, {(f % 4) == 3, 1'b0});
      chk($sformatf("ch0_idle f%0d", f), 0, 2'b00);
    end
    bus.inc[31:16] = 16'h5555;
    pulses = 0;
    for (int f = 0; f < 3000; f++) begin
      step();
      pulses += int'(bus.ce[1]);
    end
    checks++;
    assert (pulses >= 999 && pulses <= 1001) else begin
      failures++;
      $error("FAIL frac_5555 observed=%0d expected=999..1001", pulses);
    end

    // Test 5: sync mid-period on both channels.
    bus.div[7:0]   = 8'd5;
    bus.inc[31:16] = 16'h4000;
    bus.en[0]      = 1'b1;
    step();
    step();
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_mid", 0, 2'b00);
    chk("sync_mid", 1, 2'b00);
    for (int h = 0; h < 17; h++) begin
      step();
      chk($sformatf("aligned h%0d", h), 0, {(h % 6) == 5, (h % 6) == 3});
      chk($sformatf("aligned h%0d", h), 1, {(h % 4) == 3, 1'b0});
    end
    // Edge 17 would be a ch0 boundary; sync suppresses it.
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_boundary", 0, 2'b00);
    for (int j = 0; j < 6; j++) begin
      step();
      chk($sformatf("post_sync j%0d", j), 0, {j == 5, j == 3});
      chk($sformatf("post_sync j%0d", j), 1, {(j % 4) == 3, 1'b0});
    end

    // Test 6: one-cycle reset mid-operation, new ch1 params.
    step();
    step();
    bus.inc[31:16] = 16'h8000;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_reset", 0, 2'b00);
    chk("mid_reset", 1, 2'b00);
    for (int k = 0; k < 18; k++) begin
      step();
      chk($sformatf("restart k%0d", k), 0, {(k % 6) == 5, (k % 6) == 3});
      if (k < 6)
        chk($sformatf("ch1_frac k%0d", k), 1, {(k % 2) == 1, 1'b0});
      else
        chk($sformatf("ch1_int k%0d", k), 1,
            {(k == 9) || (k == 12) || (k == 15),
             (k == 8) || (k == 11) || (k == 14) || (k == 17)});
      if (k == 5) begin
        bus.mode[1]    = 1'b0;
        bus.div[15:8]  = 8'd2;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
